// File: rtl/cache_pkg.sv
// Shared types and constants for the cache miss-side line-fill engine.
package cache_pkg;

  localparam int ADDR_W         = 15;
  localparam int DATA_W         = 32;
  localparam int IDX_W          = 10;
  localparam int TAG_W          = 3;
  localparam int WORDS_PER_LINE = 4;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2,
    ST_DONE  = 2'd3
  } fill_state_e;

  typedef logic [DATA_W-1:0] word_t;

  // Packed so that element 0 lands in bits [31:0] of the flattened line.
  typedef word_t [WORDS_PER_LINE-1:0] line_t;

  function automatic logic [ADDR_W-1:0] word_addr(input logic [ADDR_W-1:0] base,
                                                  input logic [1:0]        slot);
    return base + {{(ADDR_W-2){1'b0}}, slot};
  endfunction

  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    logic [15:0] r;
    if (v == 16'hFFFF) begin
      r = v;
    end else begin
      r = v + 16'd1;
    end
    return r;
  endfunction

endpackage

// File: rtl/line_assembler.sv
// Four-slot word register file used to gather a cache line one word at a time.
// merged_o shows the contents with the current cycle's write already applied.
module line_assembler
  import cache_pkg::*;
(
  input  logic       clk_i,
  input  logic       rst_n_i,
  input  logic       clear_i,
  input  logic       wr_en_i,
  input  logic [1:0] wr_slot_i,
  input  word_t      wr_data_i,
  output line_t      merged_o
);

  line_t line_q;
  line_t line_d;

  always_comb begin
    line_d = line_q;
    if (clear_i) begin
      line_d = '0;
    end else if (wr_en_i) begin
      line_d[wr_slot_i] = wr_data_i;
    end else begin
      line_d = line_q;
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      line_q <= '0;
    end else begin
      line_q <= line_d;
    end
  end

  assign merged_o = line_d;

endmodule

// File: rtl/cache_line_fill.sv
// Miss-side line-fill engine: fetches a 4-word aligned block over a single-port
// memory interface. Optional critical-word-first order: CACHE_LINE_FILL_CRIT_FIRST_EN.
module cache_line_fill
  import cache_pkg::*;
(
  input  logic                             clk,
  input  logic                             rst_n,
  input  logic                             req_valid,
  input  logic [ADDR_W-1:0]                req_addr,
  output logic                             req_ready,
  output logic                             mem_rd,
  output logic [ADDR_W-1:0]                mem_addr,
  input  logic                             mem_rvalid,
  input  logic [DATA_W-1:0]                mem_rdata,
  output logic                             line_valid,
  output logic [WORDS_PER_LINE*DATA_W-1:0] line_data,
  output logic [IDX_W-1:0]                 line_index,
  output logic [TAG_W-1:0]                 line_tag,
  output logic [15:0]                      fill_count
`ifdef CACHE_LINE_FILL_CRIT_FIRST_EN
  ,
  output logic                             crit_valid,
  output logic [DATA_W-1:0]                crit_data
`endif
);

  fill_state_e       state_q, state_d;
  logic [1:0]        wcnt_q, wcnt_d;
  logic [1:0]        off_q, off_d;
  logic [ADDR_W-1:0] base_q, base_d;
  logic [IDX_W-1:0]  idx_q, idx_d;
  logic [TAG_W-1:0]  tag_q, tag_d;
  logic              req_ready_q, req_ready_d;
  logic              mem_rd_q, mem_rd_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic              line_valid_q, line_valid_d;
  line_t             line_data_q, line_data_d;
  logic [IDX_W-1:0]  line_index_q, line_index_d;
  logic [TAG_W-1:0]  line_tag_q, line_tag_d;
  logic [15:0]       fill_count_q, fill_count_d;

  logic              asm_clr_s;
  logic              asm_we_s;
  line_t             asm_line_s;
  logic [1:0]        slot_s;
  logic [1:0]        nxt_slot_s;
  logic [1:0]        req_off_s;
  logic [ADDR_W-1:0] req_base_s;

  // Slot is the physical word position; off_q rotates the fetch order.
  assign slot_s     = wcnt_q + off_q;
  assign nxt_slot_s = slot_s + 2'd1;
  assign req_base_s = req_addr & {{(ADDR_W-2){1'b1}}, 2'b00};

`ifdef CACHE_LINE_FILL_CRIT_FIRST_EN
  assign req_off_s  = req_addr[1:0];
  assign crit_valid = (state_q == ST_WAIT) && mem_rvalid && (wcnt_q == 2'd0);
  assign crit_data  = mem_rdata;
`else
  assign req_off_s  = 2'd0;
`endif

  line_assembler u_asm (
    .clk_i     (clk),
    .rst_n_i   (rst_n),
    .clear_i   (asm_clr_s),
    .wr_en_i   (asm_we_s),
    .wr_slot_i (slot_s),
    .wr_data_i (mem_rdata),
    .merged_o  (asm_line_s)
  );

  always_comb begin
    state_d      = state_q;
    wcnt_d       = wcnt_q;
    off_d        = off_q;
    base_d       = base_q;
    idx_d        = idx_q;
    tag_d        = tag_q;
    req_ready_d  = 1'b0;
    mem_rd_d     = 1'b0;
    mem_addr_d   = mem_addr_q;
    line_valid_d = 1'b0;
    line_data_d  = line_data_q;
    line_index_d = line_index_q;
    line_tag_d   = line_tag_q;
    fill_count_d = fill_count_q;
    asm_clr_s    = 1'b0;
    asm_we_s     = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (req_valid && req_ready_q) begin
          base_d     = req_base_s;
          idx_d      = req_addr[11:2];
          tag_d      = req_addr[14:12];
          wcnt_d     = 2'd0;
          off_d      = req_off_s;
          asm_clr_s  = 1'b1;
          mem_rd_d   = 1'b1;
          mem_addr_d = word_addr(req_base_s, req_off_s);
          state_d    = ST_ISSUE;
        end else begin
          req_ready_d = 1'b1;
        end
      end
      ST_ISSUE: begin
        state_d = ST_WAIT;
      end
      ST_WAIT: begin
        if (mem_rvalid) begin
          asm_we_s = 1'b1;
          if (wcnt_q == 2'd3) begin
            // The last word is merged in here so the line is complete in DONE.
            line_valid_d = 1'b1;
            line_data_d  = asm_line_s;
            line_index_d = idx_q;
            line_tag_d   = tag_q;
            fill_count_d = sat_inc16(fill_count_q);
            state_d      = ST_DONE;
          end else begin
            wcnt_d     = wcnt_q + 2'd1;
            mem_rd_d   = 1'b1;
            mem_addr_d = word_addr(base_q, nxt_slot_s);
            state_d    = ST_ISSUE;
          end
        end else begin
          state_d = ST_WAIT;
        end
      end
      ST_DONE: begin
        req_ready_d = 1'b1;
        state_d     = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q      <= ST_IDLE;
      wcnt_q       <= 2'd0;
      off_q        <= 2'd0;
      base_q       <= '0;
      idx_q        <= '0;
      tag_q        <= '0;
      req_ready_q  <= 1'b0;
      mem_rd_q     <= 1'b0;
      mem_addr_q   <= '0;
      line_valid_q <= 1'b0;
      line_data_q  <= '0;
      line_index_q <= '0;
      line_tag_q   <= '0;
      fill_count_q <= 16'd0;
    end else begin
      state_q      <= state_d;
      wcnt_q       <= wcnt_d;
      off_q        <= off_d;
      base_q       <= base_d;
      idx_q        <= idx_d;
      tag_q        <= tag_d;
      req_ready_q  <= req_ready_d;
      mem_rd_q     <= mem_rd_d;
      mem_addr_q   <= mem_addr_d;
      line_valid_q <= line_valid_d;
      line_data_q  <= line_data_d;
      line_index_q <= line_index_d;
      line_tag_q   <= line_tag_d;
      fill_count_q <= fill_count_d;
    end
  end

  assign req_ready  = req_ready_q;
  assign mem_rd     = mem_rd_q;
  assign mem_addr   = mem_addr_q;
  assign line_valid = line_valid_q;
  assign line_data  = line_data_q;
  assign line_index = line_index_q;
  assign line_tag   = line_tag_q;
  assign fill_count = fill_count_q;

endmodule

// File: doc/cache_line_fill.md
Name: cache_line_fill

Overview:
- Miss-side line-fill engine directly downstream of the direct-mapped cache (1024 lines × 4 words, 3-bit tag, 15-bit word address).
- On a miss request, fetches the 4-word aligned block from main memory one word at a time over a valid/response handshake.
- Assembles the 4 words and presents the completed line (data, index, tag) to the cache for a one-cycle write.
- Replaces the cache's single-cycle 4-port combinational memory read with a single-port, variable-latency memory interface.

Parameters:
- ADDR_W, 15, word address width.
- DATA_W, 32, word width.
- IDX_W, 10, cache index width (address bits [11:2]).
- TAG_W, 3, tag width (address bits [14:12]).

Ports:
- clk  in  1  rising-edge clock.
- rst_n  in  1  synchronous active-low reset.
- req_valid  in  1  cache requests a fill.
- req_addr  in  ADDR_W  missing word address.
- req_ready  out  1  engine idle, can accept a request.
- mem_rd  out  1  one-cycle read strobe to memory.
- mem_addr  out  ADDR_W  word address of the current read.
- mem_rvalid  in  1  memory read data valid.
- mem_rdata  in  DATA_W  memory read data.
- line_valid  out  1  one-cycle pulse: completed line available.
- line_data  out  4*DATA_W  word0 in [31:0] … word3 in [127:96].
- line_index  out  IDX_W  cache index of the line.
- line_tag  out  TAG_W  tag of the line.
- fill_count  out  16  number of completed fills, saturating.

Behaviour:
- Reset is synchronous, sampled on posedge clk while rst_n==0. All of the following clear to 0: state=IDLE, req_ready (set to 1 on the first cycle after reset releases), mem_rd, mem_addr, line_valid, line_data, line_index, line_tag, fill_count, word counter.
- FSM states: IDLE, ISSUE, WAIT, DONE.
- IDLE:
  - req_ready=1.
  - On req_valid=1, latch base = req_addr with bits [1:0] forced to 0, index = req_addr[11:2], tag = req_addr[14:12], wcnt=0. Go to ISSUE.
- ISSUE:
  - mem_rd=1 for exactly one cycle; mem_addr = base + wcnt.
  - Go to WAIT.
- WAIT:
  - mem_rd=0; mem_addr holds its value.
  - On mem_rvalid=1, write mem_rdata into line word slot wcnt.
  - If wcnt==3 go to DONE; else increment wcnt and go to ISSUE.
  - Stay in WAIT indefinitely without mem_rvalid; there is no timeout.
- DONE:
  - line_valid=1 for one cycle; line_data, line_index and line_tag are stable in that cycle and hold afterwards until the next fill overwrites them.
  - fill_count increments, saturating at 0xFFFF.
  - Return to IDLE.
- req_ready=0 in every state except IDLE. req_valid outside IDLE is ignored; the requester must hold it.
- mem_rvalid is sampled only in WAIT. A response in IDLE, ISSUE or DONE is discarded. A response in the same cycle as mem_rd is not permitted.
- Latency: with one-cycle memory latency, accept at cycle 0 → line_valid at cycle 9. Minimum spacing between fills is 10 cycles.
- Address boundaries: the block is aligned, so mem_addr never crosses 0x7FFF; base 0x7FFC reads 0x7FFC..0x7FFF. Arithmetic is ADDR_W-bit.
- Reset mid-fill: return to IDLE immediately, no line_valid, partial data discarded, fill_count cleared.

Optional Feature:
- Macro CACHE_LINE_FILL_CRIT_FIRST_EN.
- When defined:
  - Fill order starts at the requested word and wraps: slot = (req_addr[1:0] + wcnt) mod 4.
  - Extra outputs crit_valid (1) and crit_data (DATA_W): crit_valid pulses in the WAIT cycle that returns the first word, with crit_data = that word, so the cache can deliver data early.
  - line_data slot placement is unchanged: slot k always holds address base+k.
- When undefined: order is always word 0..3; crit_valid and crit_data are absent.

Decomposition:
- Shared package cache_pkg holds ADDR_W, DATA_W, IDX_W, TAG_W, WORDS_PER_LINE=4, the FSM state enum type, and a line_t typedef (array of 4 words).
- One sub-module, line_assembler: the 4-slot word register file with slot-indexed write enable and a clear input. The FSM stays in cache_line_fill.

Test Plan:
- Basic fill: req_addr=0x0405, memory returns mem[a]=a, 1-cycle latency → mem_addr sequence 0x404,0x405,0x406,0x407; line_valid at cycle 9; line_data={0x407,0x406,0x405,0x404}; line_index=0x101; line_tag=0; fill_count=1.
- Slow memory: 5-cycle latency → mem_rd stays 1 only in the ISSUE cycles; line_valid at cycle 25; req_ready=0 throughout the fill.
- Top-of-memory boundary: req_addr=0x7FFE → reads 0x7FFC..0x7FFF; line_tag=7; line_index=0x3FF.
- Spurious responses: mem_rvalid pulsed in IDLE and ISSUE → ignored; line_data matches only responses received in WAIT.
- Reset after word 2 of a fill → next cycle state IDLE, req_ready=1, line_valid never asserted, fill_count=0; a following fill completes correctly.
- With CACHE_LINE_FILL_CRIT_FIRST_EN: req_addr=0x0406 → mem_addr 0x406,0x407,0x404,0x405; crit_valid with crit_data=0x406 on the first response; line_data same as for order 0..3.
